// File: rtl/video_frame_checker.sv
// video_frame_checker: per-frame CRC-32 and geometry checker for a qualified pixel stream.
// Build option: define VFC_REF_COMPARE_EN to add iRefCrc / oCrcMatch, comparing each
// reported CRC against an externally supplied reference value.
// Signalling: iVde qualifies iPixel on every cycle. iAFE is a one-cycle frame-end pulse.
// oCrcVd is a one-cycle strobe that marks fresh oCrc/oFrameErr/oActiveW/oActiveH/oFrameCnt.
// Those result outputs then hold their values until the next strobe.
module video_frame_checker #(
    parameter int pColorDepth    = 4,
    parameter int pChannels      = 3,
    parameter int pHdisplayWidth = 11,
    parameter int pVdisplayWidth = 11,
    parameter int pFrameCntWidth = 8
) (
    input  logic                              iClk,
    input  logic                              iRst,
    input  logic                              iEn,
    input  logic                              iVde,
    input  logic [pChannels*pColorDepth-1:0]  iPixel,
    input  logic                              iAFE,
    input  logic [pHdisplayWidth:0]           iExpHdisplay,
    input  logic [pVdisplayWidth:0]           iExpVdisplay,
`ifdef VFC_REF_COMPARE_EN
    input  logic [31:0]                       iRefCrc,
    output logic                              oCrcMatch,
`endif
    output logic [31:0]                       oCrc,
    output logic                              oCrcVd,
    output logic                              oFrameErr,
    output logic [pFrameCntWidth-1:0]         oFrameCnt,
    output logic [pHdisplayWidth:0]           oActiveW,
    output logic [pVdisplayWidth:0]           oActiveH,
    output logic                              oBusy
);

    localparam int DW = pChannels * pColorDepth;
    localparam logic [31:0] CRC_POLY = 32'h04C1_1DB7;
    localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SYNC    = 2'd1;
    localparam logic [1:0] CAPTURE = 2'd2;
    localparam logic [1:0] REPORT  = 2'd3;

    localparam logic [pHdisplayWidth-1:0] PIX_ONE  = {{(pHdisplayWidth-1){1'b0}}, 1'b1};
    localparam logic [pVdisplayWidth-1:0] LINE_ONE = {{(pVdisplayWidth-1){1'b0}}, 1'b1};
    localparam logic [pFrameCntWidth-1:0] FCNT_ONE = {{(pFrameCntWidth-1){1'b0}}, 1'b1};

    logic [1:0]                r_state;
    logic [1:0]                w_state_next;
    logic [31:0]               r_crc;
    logic [pHdisplayWidth-1:0] r_pix_cnt;
    logic [pVdisplayWidth-1:0] r_line_cnt;
    logic [pHdisplayWidth-1:0] r_last_w;
    logic                      r_vde_prev;
    logic                      r_line_err;

    logic [31:0]               w_crc_next;
    logic [pHdisplayWidth-1:0] w_pix_cnt_inc;
    logic [pVdisplayWidth-1:0] w_line_cnt_inc;
    logic                      w_capture;
    logic                      w_afe_px;
    logic                      w_line_close;
    logic [pHdisplayWidth-1:0] w_closed_len;
    logic                      w_len_err;
    logic                      w_frame_err;
    logic [31:0]               w_final_crc;

    // MSB-first CRC-32 over the whole pixel word, highest bit first.
    function automatic logic [31:0] crc_fold(input logic [31:0] c, input logic [DW-1:0] d);
        logic [31:0] v;
        v = c;
        for (int i = DW - 1; i >= 0; i--) begin
            if (v[31] ^ d[i]) v = {v[30:0], 1'b0} ^ CRC_POLY;
            else              v = {v[30:0], 1'b0};
        end
        return v;
    endfunction

    assign w_capture      = (r_state == CAPTURE);
    assign w_crc_next     = crc_fold(r_crc, iPixel);
    assign w_pix_cnt_inc  = (&r_pix_cnt) ? r_pix_cnt : r_pix_cnt + PIX_ONE;
    assign w_line_cnt_inc = (&r_line_cnt) ? r_line_cnt : r_line_cnt + LINE_ONE;
    // A pixel coincident with the frame-end pulse belongs to the line it closes.
    assign w_afe_px       = iAFE && iVde;
    assign w_line_close   = w_capture && ((r_vde_prev && !iVde) || w_afe_px);
    assign w_closed_len   = w_afe_px ? w_pix_cnt_inc : r_pix_cnt;
    assign w_len_err      = ({1'b0, w_closed_len} != iExpHdisplay);
    assign w_frame_err    = r_line_err || ({1'b0, r_line_cnt} != iExpVdisplay);
    assign w_final_crc    = ~r_crc;
    assign oBusy          = (r_state != IDLE);

    // Next-state decode for the capture sequencer.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (iEn) w_state_next = SYNC;
            SYNC:    if (iAFE) w_state_next = CAPTURE;
            CAPTURE: if (iAFE) w_state_next = REPORT;
            REPORT:  w_state_next = iEn ? CAPTURE : IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    // Frame accumulation: CRC, pixel/line counters and the frame-sticky line error.
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            r_crc      <= '0;
            r_pix_cnt  <= '0;
            r_line_cnt <= '0;
            r_last_w   <= '0;
            r_vde_prev <= 1'b0;
            r_line_err <= 1'b0;
        end else begin
            case (r_state)
                CAPTURE: begin
                    if (iVde) r_crc <= w_crc_next;
                    r_vde_prev <= iVde && !iAFE;
                    if (w_line_close) begin
                        r_last_w   <= w_closed_len;
                        r_pix_cnt  <= '0;
                        r_line_cnt <= w_line_cnt_inc;
                        if (w_len_err || w_afe_px) r_line_err <= 1'b1;
                    end else if (iVde) begin
                        r_pix_cnt <= w_pix_cnt_inc;
                    end
                end
                REPORT: begin
                    r_crc      <= CRC_INIT;
                    r_pix_cnt  <= '0;
                    r_line_cnt <= '0;
                    r_last_w   <= '0;
                    r_vde_prev <= 1'b0;
                    // Video during the report slot is dropped, so the next frame is marked bad.
                    r_line_err <= iVde;
                end
                default: begin
                    r_crc      <= CRC_INIT;
                    r_pix_cnt  <= '0;
                    r_line_cnt <= '0;
                    r_last_w   <= '0;
                    r_vde_prev <= 1'b0;
                    r_line_err <= 1'b0;
                end
            endcase
        end
    end

    // Result registers: loaded once per frame in REPORT and held otherwise.
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            oCrc      <= '0;
            oCrcVd    <= 1'b0;
            oFrameErr <= 1'b0;
            oFrameCnt <= '0;
            oActiveW  <= '0;
            oActiveH  <= '0;
`ifdef VFC_REF_COMPARE_EN
            oCrcMatch <= 1'b0;
`endif
        end else begin
            oCrcVd <= (r_state == REPORT);
            if (r_state == REPORT) begin
                oCrc      <= w_final_crc;
                oFrameErr <= w_frame_err;
                oFrameCnt <= oFrameCnt + FCNT_ONE;
                oActiveW  <= {1'b0, r_last_w};
                oActiveH  <= {1'b0, r_line_cnt};
`ifdef VFC_REF_COMPARE_EN
                oCrcMatch <= (w_final_crc == iRefCrc) && !w_frame_err;
`endif
            end
        end
    end

endmodule

// File: tb/tb_video_frame_checker.sv
// Testbench for video_frame_checker: randomized frames checked against a frame-level
// reference model (CRC over the pixel list, geometry from the list of line lengths).
// Two instances share all inputs; the second uses a 2-bit frame counter to show wrap.
module tb_video_frame_checker;

    localparam logic [31:0] POLY = 32'h04C1_1DB7;

    logic        iClk = 1'b0;
    logic        iRst;
    logic        iEn;
    logic        iVde;
    logic [11:0] iPixel;
    logic        iAFE;
    logic [11:0] iExpHdisplay;
    logic [11:0] iExpVdisplay;
    logic [31:0] oCrc,  oCrc2;
    logic        oCrcVd, oCrcVd2;
    logic        oFrameErr, oFrameErr2;
    logic [7:0]  oFrameCnt;
    logic [1:0]  oFrameCnt2;
    logic [11:0] oActiveW, oActiveW2;
    logic [11:0] oActiveH, oActiveH2;
    logic        oBusy, oBusy2;
`ifdef VFC_REF_COMPARE_EN
    logic [31:0] iRefCrc;
    logic        oCrcMatch, oCrcMatch2;
`endif

    int checks = 0;
    int errors = 0;
    int vd_count = 0;

    // Stimulus knobs consumed by run_frame.
    int          exp_h, exp_v;
    int          line_len_q[$];
    bit          use_fixed;
    logic [11:0] fixed_pix;
    bit          afe_on_pixel;
    bit          vde_in_report;
    bit          carry_err;
    bit          ref_flip;
    int          en_drop_line;
    int          frames_done;

    video_frame_checker dut (
        .iClk(iClk), .iRst(iRst), .iEn(iEn), .iVde(iVde), .iPixel(iPixel), .iAFE(iAFE),
        .iExpHdisplay(iExpHdisplay), .iExpVdisplay(iExpVdisplay),
`ifdef VFC_REF_COMPARE_EN
        .iRefCrc(iRefCrc), .oCrcMatch(oCrcMatch),
`endif
        .oCrc(oCrc), .oCrcVd(oCrcVd), .oFrameErr(oFrameErr), .oFrameCnt(oFrameCnt),
        .oActiveW(oActiveW), .oActiveH(oActiveH), .oBusy(oBusy)
    );

    video_frame_checker #(.pFrameCntWidth(2)) dut_w2 (
        .iClk(iClk), .iRst(iRst), .iEn(iEn), .iVde(iVde), .iPixel(iPixel), .iAFE(iAFE),
        .iExpHdisplay(iExpHdisplay), .iExpVdisplay(iExpVdisplay),
`ifdef VFC_REF_COMPARE_EN
        .iRefCrc(iRefCrc), .oCrcMatch(oCrcMatch2),
`endif
        .oCrc(oCrc2), .oCrcVd(oCrcVd2), .oFrameErr(oFrameErr2), .oFrameCnt(oFrameCnt2),
        .oActiveW(oActiveW2), .oActiveH(oActiveH2), .oBusy(oBusy2)
    );

    // Clock
    always #5 iClk = ~iClk;

    // Strobe monitor
    always @(negedge iClk) if (oCrcVd === 1'b1) vd_count++;

    // Reference CRC: XOR the pixel into the top of the register, then shift it through.
    function automatic logic [31:0] model_crc(input logic [31:0] c, input logic [11:0] d);
        logic [31:0] v;
        v = c ^ {d, 20'h0};
        for (int k = 0; k < 12; k++) v = v[31] ? ((v << 1) ^ POLY) : (v << 1);
        return v;
    endfunction

    task automatic clear_knobs();
        exp_h = 4; exp_v = 2;
        line_len_q.delete();
        use_fixed = 1'b0; fixed_pix = 12'h0F0;
        afe_on_pixel = 1'b0; vde_in_report = 1'b0;
        ref_flip = 1'b0; en_drop_line = -1;
    endtask

    // IDLE -> SYNC, junk pixels that SYNC must ignore, then the frame-start pulse.
    task automatic start_capture();
        iEn = 1'b1; iVde = 1'b0; iAFE = 1'b0;
        @(negedge iClk);
        repeat (3) begin
            iVde = 1'b1; iPixel = 12'($urandom);
            @(negedge iClk);
        end
        iVde = 1'b0; iAFE = 1'b1;
        @(negedge iClk);
        iAFE = 1'b0;
        checks++;
        if (oBusy !== 1'b1) begin errors++; $display("FAIL busy_capture: got %b expected 1", oBusy); end
    endtask

    // Drive one frame from line_len_q, then check the report slot and the hold cycle.
    task automatic run_frame();
        logic [31:0] c, exp_crc;
        logic [11:0] pix;
        int n, len, w, last_w;
        bit err;
        c = 32'hFFFF_FFFF;
        n = line_len_q.size();
        err = carry_err; carry_err = 1'b0; last_w = 0;
        iExpHdisplay = 12'(exp_h); iExpVdisplay = 12'(exp_v);
        for (int i = 0; i < n; i++) begin
            if (i == en_drop_line) iEn = 1'b0;
            len = line_len_q[i];
            for (int j = 0; j < len; j++) begin
                pix = use_fixed ? fixed_pix : 12'($urandom);
                c = model_crc(c, pix);
                iVde = 1'b1; iPixel = pix;
                iAFE = afe_on_pixel && (i == n - 1) && (j == len - 1);
                @(negedge iClk);
            end
            w = (len > 2047) ? 2047 : len;
            last_w = w;
            if (w != exp_h) err = 1'b1;
            if (!(afe_on_pixel && i == n - 1)) begin
                iVde = 1'b0; iAFE = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge iClk);
            end
        end
        if (afe_on_pixel && n > 0) err = 1'b1;
        else begin
            iVde = 1'b0; iAFE = 1'b1;
            @(negedge iClk);
        end
        if (n != exp_v) err = 1'b1;
        exp_crc = ~c;
        frames_done++;
        iAFE = 1'b0; iVde = vde_in_report; iPixel = 12'($urandom);
`ifdef VFC_REF_COMPARE_EN
        iRefCrc = ref_flip ? (exp_crc ^ 32'h1) : exp_crc;
`endif
        checks++;
        if (oCrcVd !== 1'b0) begin errors++; $display("FAIL vd_early: got %b expected 0", oCrcVd); end
        @(negedge iClk);
        iVde = 1'b0;
        checks++;
        if (oCrcVd !== 1'b1) begin errors++; $display("FAIL vd_pulse: got %b expected 1", oCrcVd); end
        checks++;
        if (oCrc !== exp_crc) begin errors++; $display("FAIL crc: got %h expected %h", oCrc, exp_crc); end
        checks++;
        if (oActiveW !== 12'(last_w)) begin errors++; $display("FAIL active_w: got %0d expected %0d", oActiveW, last_w); end
        checks++;
        if (oActiveH !== 12'(n)) begin errors++; $display("FAIL active_h: got %0d expected %0d", oActiveH, n); end
        checks++;
        if (oFrameErr !== err) begin errors++; $display("FAIL frame_err: got %b expected %b", oFrameErr, err); end
        checks++;
        if (oFrameCnt !== 8'(frames_done)) begin errors++; $display("FAIL frame_cnt: got %0d expected %0d", oFrameCnt, frames_done % 256); end
        checks++;
        if (oFrameCnt2 !== 2'(frames_done)) begin errors++; $display("FAIL frame_cnt_w2: got %0d expected %0d", oFrameCnt2, frames_done % 4); end
        checks++;
        if ({oCrc2, oFrameErr2, oActiveW2, oActiveH2, oCrcVd2} !== {exp_crc, err, 12'(last_w), 12'(n), 1'b1}) begin
            errors++; $display("FAIL w2_results: got %h/%b/%0d/%0d expected %h/%b/%0d/%0d",
                                oCrc2, oFrameErr2, oActiveW2, oActiveH2, exp_crc, err, last_w, n);
        end
`ifdef VFC_REF_COMPARE_EN
        checks++;
        if (oCrcMatch !== (!ref_flip && !err)) begin errors++; $display("FAIL crc_match: got %b expected %b", oCrcMatch, (!ref_flip && !err)); end
`endif
        if (vde_in_report) carry_err = 1'b1;
        @(negedge iClk);
        checks++;
        if ({oCrcVd, oCrc} !== {1'b0, exp_crc}) begin errors++; $display("FAIL hold: got %b/%h expected 0/%h", oCrcVd, oCrc, exp_crc); end
    endtask

    task automatic do_reset();
        iRst = 1'b0; iEn = 1'b0; iVde = 1'b0; iAFE = 1'b0;
        repeat (2) @(negedge iClk);
        iRst = 1'b1;
        frames_done = 0; carry_err = 1'b0;
    endtask

    task automatic test_reset();
        iRst = 1'b0; iEn = 1'b0; iVde = 1'b0; iAFE = 1'b0; iPixel = '0;
        iExpHdisplay = '0; iExpVdisplay = '0;
`ifdef VFC_REF_COMPARE_EN
        iRefCrc = '0;
`endif
        repeat (2) @(negedge iClk);
        checks++;
        if ({oCrc, oCrcVd, oFrameErr, oFrameCnt, oActiveW, oActiveH, oBusy} !== '0) begin
            errors++; $display("FAIL reset_outputs: got %h/%b/%b/%0d/%0d/%0d/%b expected all zero",
                                oCrc, oCrcVd, oFrameErr, oFrameCnt, oActiveW, oActiveH, oBusy);
        end
        iRst = 1'b1;
        frames_done = 0; carry_err = 1'b0;
        @(negedge iClk);
        checks++;
        if (oBusy !== 1'b0) begin errors++; $display("FAIL idle_after_reset: got %b expected 0", oBusy); end
    endtask

    task automatic test_clean_frame();
        clear_knobs();
        start_capture();
        use_fixed = 1'b1;
        line_len_q = '{4, 4};
        run_frame();
        use_fixed = 1'b0;
        run_frame();
    endtask

    task automatic test_short_line();
        clear_knobs();
        line_len_q = '{4, 3};
        run_frame();
    endtask

    task automatic test_extra_line();
        clear_knobs();
        line_len_q = '{4, 4, 4};
        run_frame();
        line_len_q = '{4, 4};
        run_frame();
    endtask

    task automatic test_afe_with_vde();
        clear_knobs();
        afe_on_pixel = 1'b1;
        line_len_q = '{4, 4};
        run_frame();
        clear_knobs();
        line_len_q = '{4, 4};
        run_frame();
    endtask

    task automatic test_vde_in_report();
        clear_knobs();
        line_len_q = '{4, 4};
        vde_in_report = 1'b1;
        run_frame();
        vde_in_report = 1'b0;
        run_frame();
        run_frame();
    endtask

    task automatic test_saturation();
        clear_knobs();
        exp_h = 2047; exp_v = 1;
        line_len_q = '{2050};
        run_frame();
    endtask

    task automatic test_random_frames();
        int nl;
        for (int f = 0; f < 8; f++) begin
            clear_knobs();
            exp_h = $urandom_range(2, 6);
            exp_v = $urandom_range(1, 3);
            nl = exp_v + (($urandom_range(0, 3) == 0) ? 1 : 0);
            for (int l = 0; l < nl; l++)
                line_len_q.push_back(($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : exp_h);
            afe_on_pixel = ($urandom_range(0, 4) == 0);
            run_frame();
        end
    endtask

    task automatic test_enable_drop();
        int base;
        clear_knobs();
        line_len_q = '{4, 4};
        en_drop_line = 1;
        run_frame();
        checks++;
        if ({oBusy, oBusy2} !== 2'b00) begin errors++; $display("FAIL busy_after_drop: got %b expected 00", {oBusy, oBusy2}); end
        base = vd_count;
        iAFE = 1'b1;
        @(negedge iClk);
        iAFE = 1'b0;
        repeat (3) @(negedge iClk);
        checks++;
        if (vd_count !== base || oBusy !== 1'b0) begin
            errors++; $display("FAIL idle_afe_ignored: got strobes %0d busy %b expected 0 0", vd_count - base, oBusy);
        end
        start_capture();
        clear_knobs();
        line_len_q = '{4, 4};
        run_frame();
    endtask

    task automatic test_reset_mid_line();
        int base;
        clear_knobs();
        iExpHdisplay = 12'd4; iExpVdisplay = 12'd2;
        repeat (2) begin
            iVde = 1'b1; iPixel = 12'($urandom);
            @(negedge iClk);
        end
        iRst = 1'b0;
        #1;
        checks++;
        if ({oCrc, oCrcVd, oFrameErr, oFrameCnt, oActiveW, oActiveH, oBusy, oFrameCnt2} !== '0) begin
            errors++; $display("FAIL async_reset: got %h/%b/%b/%0d/%0d/%0d/%b expected all zero",
                                oCrc, oCrcVd, oFrameErr, oFrameCnt, oActiveW, oActiveH, oBusy);
        end
        @(negedge iClk);
        iVde = 1'b0;
        iRst = 1'b1;
        frames_done = 0; carry_err = 1'b0;
        base = vd_count;
        start_capture();
        line_len_q = '{4, 4};
        run_frame();
        checks++;
        if (vd_count - base !== 1) begin errors++; $display("FAIL strobes_after_reset: got %0d expected 1", vd_count - base); end
    endtask

    task automatic test_frame_cnt_wrap();
        do_reset();
        clear_knobs();
        start_capture();
        line_len_q = '{4, 4};
        repeat (5) run_frame();
    endtask

`ifdef VFC_REF_COMPARE_EN
    task automatic test_ref_compare();
        clear_knobs();
        line_len_q = '{4, 4};
        run_frame();
        ref_flip = 1'b1;
        run_frame();
    endtask
`endif

    initial begin
        clear_knobs();
        frames_done = 0; carry_err = 1'b0;
        test_reset();
        test_clean_frame();
        test_short_line();
        test_extra_line();
        test_afe_with_vde();
        test_vde_in_report();
        test_saturation();
        test_random_frames();
        test_enable_drop();
        test_reset_mid_line();
        test_frame_cnt_wrap();
`ifdef VFC_REF_COMPARE_EN
        test_ref_compare();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
